seq_mult_n: RTL and testbench

//  Parametrised iterative shift-add multiplier; signed or unsigned mode selectable per operation.

---
 rtl/seq_mult_n_pkg.sv | 11 +
 rtl/seq_mult_n_twoscomp.sv | 11 +
 rtl/seq_mult_n.sv | 90 +++++++++
 tb/tb_seq_mult_n.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_n_pkg.sv
// Shared constants for the iterative shift-add multiplier: state encodings and default width.
package seq_mult_n_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] MULT_ST_IDLE = 2'd0;
    localparam logic [1:0] MULT_ST_RUN  = 2'd1;
    localparam logic [1:0] MULT_ST_FIX  = 2'd2;
    localparam logic [1:0] MULT_ST_DONE = 2'd3;

endpackage

// File: rtl/seq_mult_n_twoscomp.sv
// Combinational N-bit two's-complement negate, shared by operand magnitude and result sign fix-up.
module seq_mult_n_twoscomp #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    assign y = ~x + {{(N-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_mult_n.sv
// Iterative shift-add multiplier, one multiplier bit per clock, signed/unsigned per operation.
// Optional build macro MULT_EARLY_TERM_EN stops RUN once the remaining multiplier bits are zero.
module seq_mult_n
    import seq_mult_n_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic               neg;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   negA, negB, absA, absB;
    logic [2*WIDTH-1:0] negAcc, accSum;
    logic               opNeg, accept, runExit;

    seq_mult_n_twoscomp #(.N(WIDTH))   u_negA   (.x(a),   .y(negA));
    seq_mult_n_twoscomp #(.N(WIDTH))   u_negB   (.x(b),   .y(negB));
    seq_mult_n_twoscomp #(.N(2*WIDTH)) u_negAcc (.x(acc), .y(negAcc));

    // The most-negative operand negates to itself, which read unsigned is exactly 2^(W-1).
    assign absA   = (is_signed & a[WIDTH-1]) ? negA : a;
    assign absB   = (is_signed & b[WIDTH-1]) ? negB : b;
    assign opNeg  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (|a) & (|b);
    assign accept = start & ((state == MULT_ST_IDLE) | (state == MULT_ST_DONE));
    assign accSum = mplier[0] ? acc + mcand : acc;

`ifdef MULT_EARLY_TERM_EN
    assign runExit = (cnt == LAST) | (mplier[WIDTH-1:1] == '0);
`else
    assign runExit = (cnt == LAST);
`endif

    assign busy = (state == MULT_ST_RUN) | (state == MULT_ST_FIX);
    assign done = (state == MULT_ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MULT_ST_IDLE;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            state  <= MULT_ST_RUN;
            neg    <= opNeg;
            mcand  <= {{WIDTH{1'b0}}, absA};
            mplier <= absB;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                MULT_ST_RUN: begin
                    acc    <= accSum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (runExit) state <= MULT_ST_FIX;
                end
                MULT_ST_FIX: begin
                    {hi, lo} <= neg ? negAcc : acc;
                    state    <= MULT_ST_DONE;
                end
                MULT_ST_DONE: state <= MULT_ST_IDLE;
                default:      state <= MULT_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_n.sv
// Self-checking bench for seq_mult_n at WIDTH=32 and WIDTH=8, scoreboard of expected products and latencies.
module tb_seq_mult_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sgn = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    seq_mult_n #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    seq_mult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    function automatic logic [63:0] model32(logic [31:0] x, logic [31:0] y, logic s);
        logic signed [63:0] sx, sy;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        if (s) return sx * sy;
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [15:0] model8(logic [7:0] x, logic [7:0] y, logic s);
        logic signed [15:0] sx, sy;
        sx = $signed({{8{x[7]}}, x});
        sy = $signed({{8{y[7]}}, y});
        if (s) return sx * sy;
        return {8'd0, x} * {8'd0, y};
    endfunction

    // Number of RUN cycles for a given multiplier magnitude in this build.
    function automatic int rCycles(int w, logic [31:0] mag);
        int r;
        int msb;
        msb = 0;
        for (int i = 0; i < w; i++) if (mag[i]) msb = i + 1;
`ifdef MULT_EARLY_TERM_EN
        r = (msb == 0) ? 1 : msb;
`else
        r = w + 0 * msb;
`endif
        return r;
    endfunction

    // Called at a falling edge; leaves start low at the falling edge after the accept edge.
    task automatic driveStart(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t e;
        logic [31:0] mag;
        mag    = (s && y[31]) ? -y : y;
        e.prod = model32(x, y, s);
        e.lat  = rCycles(32, mag) + 1;
        sb.push_back(e);
        start = 1'b1; a = x; b = y; sgn = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; sgn = ~s;
    endtask

    task automatic driveStart8(input logic [7:0] x, input logic [7:0] y, input logic s);
        exp_t e;
        logic [7:0] mag;
        mag    = (s && y[7]) ? -y : y;
        e.prod = {48'd0, model8(x, y, s)};
        e.lat  = rCycles(8, {24'd0, mag}) + 1;
        sb.push_back(e);
        start8 = 1'b1; a8 = x; b8 = y; sgn8 = s;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            nFails++;
            $display("[TB] FAIL reset32: got busy=%b done=%b hi=%h lo=%h, expected all zero", busy, done, hi, lo);
        end
        nChecks++;
        if ({busy8, done8, hi8, lo8} !== 18'd0) begin
            nFails++;
            $display("[TB] FAIL reset8: got busy=%b done=%b hi=%h lo=%h, expected all zero", busy8, done8, hi8, lo8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max;
        exp_t e;
        int lat, busyBad;
        driveStart(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lat = 0; busyBad = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (busy !== 1'b1) busyBad++;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        nChecks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            nFails++;
            $display("[TB] FAIL umax_product: got %h_%h expected FFFFFFFE_00000001", hi, lo);
        end
        nChecks++;
        if (lat !== e.lat) begin
            nFails++;
            $display("[TB] FAIL umax_latency: got %0d expected %0d", lat, e.lat);
        end
        nChecks++;
        if (busyBad !== 0) begin
            nFails++;
            $display("[TB] FAIL umax_busy: got %0d low cycles expected 0", busyBad);
        end
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== e.prod) begin
            nFails++;
            $display("[TB] FAIL umax_after: got done=%b busy=%b prod=%h expected 0 0 %h", done, busy, {hi, lo}, e.prod);
        end
    endtask

    task automatic test_signed;
        logic [31:0] ta[3] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] tb[3] = '{32'h00000001, 32'h80000000, 32'h00000006};
        logic [63:0] tp[3] = '{64'hFFFFFFFF_FFFFFFFF, 64'h40000000_00000000, 64'hFFFFFFFF_FFFFFFD6};
        exp_t e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            driveStart(ta[i], tb[i], 1'b1);
            waitDone(lat);
            e = sb.pop_front();
            nChecks++;
            if ({hi, lo} !== tp[i] || {hi, lo} !== e.prod) begin
                nFails++;
                $display("[TB] FAIL signed_%0d: got %h expected %h", i, {hi, lo}, tp[i]);
            end
            nChecks++;
            if (lat !== e.lat) begin
                nFails++;
                $display("[TB] FAIL signed_lat_%0d: got %0d expected %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_width8;
        exp_t e;
        int lat;
        logic [15:0] want[2] = '{16'hFFFE, 16'h01FE};
        for (int i = 0; i < 2; i++) begin
            driveStart8(8'hFF, 8'h02, (i == 0));
            lat = 0;
            while (done8 !== 1'b1 && lat < 300) begin
                @(negedge clk);
                lat++;
            end
            e = sb.pop_front();
            nChecks++;
            if ({hi8, lo8} !== want[i] || {hi8, lo8} !== e.prod[15:0]) begin
                nFails++;
                $display("[TB] FAIL w8_%0d: got %h expected %h", i, {hi8, lo8}, want[i]);
            end
            nChecks++;
            if (lat !== e.lat) begin
                nFails++;
                $display("[TB] FAIL w8_lat_%0d: got %0d expected %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_ignored_start;
        exp_t e;
        int lat;
        driveStart(32'h12345678, 32'h9ABCDEF1, 1'b0);
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (lat == 4) begin
                start = 1'b1; a = 32'h00000003; b = 32'h00000005; sgn = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        nChecks++;
        if ({hi, lo} !== e.prod) begin
            nFails++;
            $display("[TB] FAIL ignored_start_prod: got %h expected %h", {hi, lo}, e.prod);
        end
        nChecks++;
        if (lat !== e.lat) begin
            nFails++;
            $display("[TB] FAIL ignored_start_lat: got %0d expected %0d", lat, e.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat;
        driveStart(32'h0000FFFF, 32'h00010001, 1'b0);
        waitDone(lat);
        e = sb.pop_front();
        nChecks++;
        if ({hi, lo} !== e.prod || lat !== e.lat) begin
            nFails++;
            $display("[TB] FAIL b2b_first: got %h lat %0d expected %h lat %0d", {hi, lo}, lat, e.prod, e.lat);
        end
        driveStart(32'hFFFFFFFE, 32'h00000003, 1'b1);
        waitDone(lat);
        e = sb.pop_front();
        nChecks++;
        if ({hi, lo} !== e.prod) begin
            nFails++;
            $display("[TB] FAIL b2b_second: got %h expected %h", {hi, lo}, e.prod);
        end
        nChecks++;
        if (lat + 1 !== e.lat + 1) begin
            nFails++;
            $display("[TB] FAIL b2b_interval: got %0d cycles expected %0d", lat + 1, e.lat + 1);
        end
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int lat, doneSeen;
        driveStart(32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
        lat = 0;
        while (lat < 9) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        nChecks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            nFails++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        doneSeen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        nChecks++;
        if (doneSeen !== 0) begin
            nFails++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen);
        end
        driveStart(32'h00000007, 32'hFFFFFFF9, 1'b1);
        waitDone(lat);
        e = sb.pop_front();
        nChecks++;
        if ({hi, lo} !== e.prod || lat !== e.lat) begin
            nFails++;
            $display("[TB] FAIL abort_fresh: got %h lat %0d expected %h lat %0d", {hi, lo}, lat, e.prod, e.lat);
        end
    endtask

    task automatic test_edge_operands;
        logic [31:0] ta[3] = '{32'h00000000, 32'h00000005, 32'h80000000};
        logic [31:0] tb[3] = '{32'h80000000, 32'h00000000, 32'h00000003};
        exp_t e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            driveStart(ta[i], tb[i], 1'b1);
            waitDone(lat);
            e = sb.pop_front();
            nChecks++;
            if ({hi, lo} !== e.prod || lat !== e.lat) begin
                nFails++;
                $display("[TB] FAIL edge_%0d: got %h lat %0d expected %h lat %0d", i, {hi, lo}, lat, e.prod, e.lat);
            end
        end
    endtask

    task automatic test_random_sweep;
        exp_t e;
        int lat;
        logic [31:0] x, y;
        logic s;
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            y = (i < 4) ? 32'($urandom_range(0, 255)) : $urandom;
            s = 1'($urandom_range(0, 1));
            driveStart(x, y, s);
            waitDone(lat);
            e = sb.pop_front();
            nChecks++;
            if ({hi, lo} !== e.prod || lat !== e.lat) begin
                nFails++;
                $display("[TB] FAIL random_%0d: got %h lat %0d expected %h lat %0d", i, {hi, lo}, lat, e.prod, e.lat);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_unsigned_max;
        test_signed;
        test_width8;
        test_ignored_start;
        test_back_to_back;
        test_reset_abort;
        test_edge_operands;
        test_random_sweep;
        nChecks++;
        if (sb.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
